// File: rtl/vp_validator.sv
// vp_validator: in-order queue that checks each value prediction against the retired result and drives predictor feedback.
module vp_validator #(
  parameter int P_CONF_WIDTH = 8,
  parameter int P_DEPTH      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0][31:1]             pred_pc_i,
  input  logic [1:0][31:0]             pred_result_i,
  input  logic [1:0][P_CONF_WIDTH:0]   pred_conf_i,
  input  logic [1:0]                   pred_valid_i,
  input  logic [1:0][31:1]             ret_pc_i,
  input  logic [1:0][31:0]             ret_actual_i,
  input  logic [1:0]                   ret_valid_i,
  input  logic                         flush_i,
  output logic [1:0][31:1]             fb_pc_o,
  output logic [1:0][31:0]             fb_actual_o,
  output logic [1:0]                   fb_mispredict_o,
  output logic [1:0][P_CONF_WIDTH:0]   fb_conf_o,
  output logic [1:0]                   fb_valid_o,
  output logic                         full_o,
  output logic [$clog2(P_DEPTH):0]     count_o,
  output logic                         err_o
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;
  logic [31:1]           r_pc   [P_DEPTH];
  logic [31:0]           r_res  [P_DEPTH];
  logic [P_CONF_WIDTH:0] r_conf [P_DEPTH];
  logic [AW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_err;
  logic [1:0][31:1]           r_fb_pc;
  logic [1:0][31:0]           r_fb_actual;
  logic [1:0]                 r_fb_mis, r_fb_valid;
  logic [1:0][P_CONF_WIDTH:0] r_fb_conf;
  logic [1:0]    w_deq_ok, w_enq_ok, w_pc_ok;
  logic [CW-1:0] w_deq_n, w_enq_n, w_free;
  logic [AW-1:0] w_rd [2];
  logic [AW-1:0] w_wr [2];
  logic          w_err;
  // Free space counts this cycle's pops so a full queue can sustain 2-in/2-out.
  always_comb begin
    w_deq_ok[0] = ret_valid_i[0] && r_count != '0;
    w_deq_ok[1] = ret_valid_i[1] && r_count > CW'(w_deq_ok[0]);
    w_deq_n     = CW'(w_deq_ok[0]) + CW'(w_deq_ok[1]);
    w_free      = CW'(P_DEPTH) - r_count + w_deq_n;
    w_enq_ok[0] = pred_valid_i[0] && !flush_i && w_free != '0;
    w_enq_ok[1] = pred_valid_i[1] && !flush_i && w_free > CW'(w_enq_ok[0]);
    w_enq_n     = CW'(w_enq_ok[0]) + CW'(w_enq_ok[1]);
    w_rd[0]     = r_head;
    w_rd[1]     = r_head + AW'(w_deq_ok[0]);
    w_wr[0]     = r_tail;
    w_wr[1]     = r_tail + AW'(w_enq_ok[0]);
    w_pc_ok[0]  = r_pc[w_rd[0]] == ret_pc_i[0];
    w_pc_ok[1]  = r_pc[w_rd[1]] == ret_pc_i[1];
    w_err       = |(ret_valid_i & ~w_deq_ok) | |(w_deq_ok & ~w_pc_ok) |
                  (!flush_i && |(pred_valid_i & ~w_enq_ok));
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (w_enq_ok[k]) begin
        r_pc[w_wr[k]]   <= pred_pc_i[k];
        r_res[w_wr[k]]  <= pred_result_i[k];
        r_conf[w_wr[k]] <= pred_conf_i[k];
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_fb_pc     <= '0;
      r_fb_actual <= '0;
      r_fb_mis    <= '0;
      r_fb_conf   <= '0;
      r_fb_valid  <= '0;
    end else begin
      r_head  <= flush_i ? r_tail : r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= flush_i ? '0 : r_count + w_enq_n - w_deq_n;
      r_err   <= r_err | w_err;
      for (int k = 0; k < 2; k++) begin
        r_fb_valid[k]  <= w_deq_ok[k] && w_pc_ok[k];
        r_fb_pc[k]     <= r_pc[w_rd[k]];
        r_fb_actual[k] <= ret_actual_i[k];
        r_fb_mis[k]    <= r_res[w_rd[k]] != ret_actual_i[k];
        r_fb_conf[k]   <= r_conf[w_rd[k]];
      end
    end
  end
  assign fb_pc_o         = r_fb_pc;
  assign fb_actual_o     = r_fb_actual;
  assign fb_mispredict_o = r_fb_mis;
  assign fb_conf_o       = r_fb_conf;
  assign fb_valid_o      = r_fb_valid;
  assign count_o         = r_count;
  assign full_o          = (CW'(P_DEPTH) - r_count) < CW'(2);
  assign err_o           = r_err;
endmodule

// File: tb/tb_vp_validator.sv
// tb_vp_validator: table-driven vectors plus directed multi-cycle sequences for vp_validator.
module tb_vp_validator;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:1] pred_pc;
  logic [1:0][31:0] pred_result;
  logic [1:0][8:0]  pred_conf;
  logic [1:0]       pred_valid;
  logic [1:0][31:1] ret_pc;
  logic [1:0][31:0] ret_actual;
  logic [1:0]       ret_valid;
  logic             flush;
  logic [1:0][31:1] fb_pc;
  logic [1:0][31:0] fb_actual;
  logic [1:0]       fb_mis;
  logic [1:0][8:0]  fb_conf;
  logic [1:0]       fb_valid;
  logic             full;
  logic [4:0]       count;
  logic             err;
  int n_cmp = 0;
  int n_bad = 0;
  vp_validator #(.P_CONF_WIDTH(8), .P_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .pred_pc_i(pred_pc), .pred_result_i(pred_result), .pred_conf_i(pred_conf), .pred_valid_i(pred_valid),
    .ret_pc_i(ret_pc), .ret_actual_i(ret_actual), .ret_valid_i(ret_valid), .flush_i(flush),
    .fb_pc_o(fb_pc), .fb_actual_o(fb_actual), .fb_mispredict_o(fb_mis), .fb_conf_o(fb_conf),
    .fb_valid_o(fb_valid), .full_o(full), .count_o(count), .err_o(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  pv;
    logic [31:0] p0, r0, p1, r1;
    logic [1:0]  rv;
    logic [31:0] q0, a0, q1, a1;
    logic [1:0]  efv, emis;
    int          ecnt;
  } vec_t;
  vec_t vecs [7];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [1:0] pv, input logic [31:0] p0, r0, p1, r1,
                       input logic [1:0] rv, input logic [31:0] q0, a0, q1, a1, input logic fl);
    pred_valid = pv; pred_pc[0] = p0[30:0]; pred_result[0] = r0; pred_pc[1] = p1[30:0]; pred_result[1] = r1;
    ret_valid = rv;  ret_pc[0] = q0[30:0];  ret_actual[0] = a0;  ret_pc[1] = q1[30:0];  ret_actual[1] = a1;
    flush = fl;
    @(posedge clk);
    #1;
    pred_valid = 2'b00; ret_valid = 2'b00; flush = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic [31:0] qp [$];
    logic [31:0] qr [$];
    logic [31:0] e0p, e0r, e1p, e1r;
    rst = 1'b1; flush = 1'b0; pred_valid = 2'b00; ret_valid = 2'b00;
    pred_pc = '0; pred_result = '0; ret_pc = '0; ret_actual = '0;
    pred_conf[0] = 9'h1FF; pred_conf[1] = 9'h0A5;
    @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_fbv", fb_valid, 0);
    do_reset();
    vecs[0] = '{2'b01, 'h100, 5, 0, 0,     2'b00, 0, 0, 0, 0,          2'b00, 2'b00, 1};
    vecs[1] = '{2'b00, 0, 0, 0, 0,         2'b01, 'h100, 5, 0, 0,      2'b01, 2'b00, 0};
    vecs[2] = '{2'b11, 'h200, 7, 'h204, 9, 2'b00, 0, 0, 0, 0,          2'b00, 2'b00, 2};
    vecs[3] = '{2'b00, 0, 0, 0, 0,         2'b11, 'h200, 7, 'h204, 8,  2'b11, 2'b10, 0};
    vecs[4] = '{2'b10, 0, 0, 'h300, 3,     2'b00, 0, 0, 0, 0,          2'b00, 2'b00, 1};
    vecs[5] = '{2'b01, 'h304, 4, 0, 0,     2'b10, 0, 0, 'h300, 3,      2'b10, 2'b00, 1};
    vecs[6] = '{2'b00, 0, 0, 0, 0,         2'b01, 'h304, 5, 0, 0,      2'b01, 2'b01, 0};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].pv, vecs[i].p0, vecs[i].r0, vecs[i].p1, vecs[i].r1,
            vecs[i].rv, vecs[i].q0, vecs[i].a0, vecs[i].q1, vecs[i].a1, 1'b0);
      check($sformatf("v%0d_fbv", i), fb_valid, vecs[i].efv);
      check($sformatf("v%0d_mis", i), fb_mis & vecs[i].efv, vecs[i].emis);
      check($sformatf("v%0d_cnt", i), count, vecs[i].ecnt);
      check($sformatf("v%0d_err", i), err, 0);
      if (i == 1) begin
        check("basic_pc", fb_pc[0], 'h100);
        check("basic_conf", fb_conf[0], 'h1FF);
        check("basic_act", fb_actual[0], 5);
      end
      if (i == 3) check("dual_conf1", fb_conf[1], 'h0A5);
    end
    // fill, then sustained 2-in/2-out across pointer wrap
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 'h1000 + n, n * 3 + 1, 'h1000 + n + 1, (n + 1) * 3 + 1, 2'b00, 0, 0, 0, 0, 1'b0);
      for (int j = 0; j < 2; j++) begin qp.push_back('h1000 + n); qr.push_back(n * 3 + 1); n++; end
    end
    check("fill_cnt", count, 16);
    check("fill_full", full, 1);
    for (int i = 0; i < 20; i++) begin
      e0p = qp.pop_front(); e0r = qr.pop_front(); e1p = qp.pop_front(); e1r = qr.pop_front();
      drive(2'b11, 'h1000 + n, n * 3 + 1, 'h1000 + n + 1, (n + 1) * 3 + 1, 2'b11, e0p, e0r, e1p, e1r, 1'b0);
      for (int j = 0; j < 2; j++) begin qp.push_back('h1000 + n); qr.push_back(n * 3 + 1); n++; end
      check("wrap_fbv", fb_valid, 2'b11);
      check("wrap_mis", fb_mis, 2'b00);
      check("wrap_pc0", fb_pc[0], e0p);
      check("wrap_pc1", fb_pc[1], e1p);
      check("wrap_cnt", count, 16);
      check("wrap_err", err, 0);
    end
    // flush with concurrent retire and enqueue
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b11, 'h2000 + 4 * i, i, 'h2002 + 4 * i, i + 10, 2'b00, 0, 0, 0, 0, 1'b0);
    check("fl_pre_cnt", count, 6);
    drive(2'b11, 'h2100, 1, 'h2102, 2, 2'b01, 'h2000, 0, 0, 0, 1'b1);
    check("fl_fbv", fb_valid, 2'b01);
    check("fl_cnt", count, 0);
    check("fl_err", err, 0);
    drive(2'b00, 0, 0, 0, 0, 2'b01, 'h2002, 10, 0, 0, 1'b0);
    check("fl_under_fbv", fb_valid, 2'b00);
    check("fl_under_err", err, 1);
    // pc mismatch still pops the entry
    do_reset();
    drive(2'b01, 'h304, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0);
    drive(2'b00, 0, 0, 0, 0, 2'b01, 'h300, 1, 0, 0, 1'b0);
    check("pcm_fbv", fb_valid, 2'b00);
    check("pcm_err", err, 1);
    check("pcm_cnt", count, 0);
    // overflow at 15 entries keeps lane 0 only
    do_reset();
    for (int i = 0; i < 7; i++) drive(2'b11, 'h400 + 4 * i, i, 'h402 + 4 * i, i, 2'b00, 0, 0, 0, 0, 1'b0);
    drive(2'b01, 'h480, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0);
    check("ovf_pre_cnt", count, 15);
    check("ovf_pre_full", full, 1);
    check("ovf_pre_err", err, 0);
    drive(2'b11, 'h500, 0, 'h502, 0, 2'b00, 0, 0, 0, 0, 1'b0);
    check("ovf_cnt", count, 16);
    check("ovf_err", err, 1);
    // an entry is not retirable in its enqueue cycle
    do_reset();
    drive(2'b01, 'h600, 6, 0, 0, 2'b01, 'h600, 6, 0, 0, 1'b0);
    check("same_fbv", fb_valid, 2'b00);
    check("same_cnt", count, 1);
    check("same_err", err, 1);
    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b11, 'h700 + 4 * i, i, 'h702 + 4 * i, i, 2'b00, 0, 0, 0, 0, 1'b0);
    drive(2'b01, 'h70C, 9, 0, 0, 2'b11, 'h700, 0, 'h702, 0, 1'b0);
    check("ar_pre_fbv", fb_valid, 2'b11);
    check("ar_pre_cnt", count, 5);
    #2;
    rst = 1'b1;
    #1;
    check("ar_fbv", fb_valid, 2'b00);
    check("ar_fbpc", fb_pc, 0);
    check("ar_cnt", count, 0);
    check("ar_full", full, 0);
    check("ar_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 2'b01, 'h704, 1, 0, 0, 1'b0);
    check("ar_post_err", err, 1);
    check("ar_post_fbv", fb_valid, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vp_validator.md
# vp_validator

Feedback-side companion to the value predictor wrapper: tracks every prediction issued at Decode in an in-order queue and compares it against the architected result when the instruction retires. It then drives the predictor's validation interface: `fb_pc`, `fb_actual`, `fb_mispredict`, `fb_conf` and `fb_valid`. It sits between the predictor outputs, the retirement stage and the predictor feedback inputs. It supports two predictions and two retirements per cycle.

## Interface
- `P_CONF_WIDTH`, 8: confidence field is `P_CONF_WIDTH+1` bits, matching the predictor.
- `P_DEPTH`, 16: queue entries; must be a power of two and at least 4.
- `clk_i` in 1: main clock.
- `rst_i` in 1: reset, asynchronous and active-high; clears all state.
- `pred_pc_i` in [1:0][31:1]: PC of each predicted instruction. Lane 0 is older.
- `pred_result_i` in [1:0][31:0]: predicted value.
- `pred_conf_i` in [1:0][P_CONF_WIDTH:0]: confidence attached to the prediction.
- `pred_valid_i` in [1:0]: enqueue qualifier per lane.
- `ret_pc_i` in [1:0][31:1]: PC of each retiring predicted instruction. Lane 0 is older.
- `ret_actual_i` in [1:0][31:0]: true execution result.
- `ret_valid_i` in [1:0]: retire qualifier per lane.
- `flush_i` in 1: pipeline flush; discards all queued entries.
- `fb_pc_o` out [1:0][31:1]: feedback address.
- `fb_actual_o` out [1:0][31:0]: feedback true result.
- `fb_mispredict_o` out [1:0]: 1 when the stored prediction differs from the actual result.
- `fb_conf_o` out [1:0][P_CONF_WIDTH:0]: stored confidence of the validated prediction.
- `fb_valid_o` out [1:0]: feedback qualifier.
- `full_o` out 1: fewer than 2 free entries. Upstream must not enqueue while it is high.
- `count_o` out [$clog2(P_DEPTH):0]: occupied entries.
- `err_o` out 1: sticky protocol error flag; cleared only by `rst_i`.

## Operation
- **Storage:** circular queue of {pc, result, conf}, with head (read) and tail (write) pointers of `$clog2(P_DEPTH)` bits. Both pointers wrap modulo `P_DEPTH`.
- **Enqueue:**
  - Valid lanes are written in lane order (lane 0 first) at tail, tail+1.
  - Pattern 2'b10 writes only lane 1, at tail.
  - enq = popcount(`pred_valid_i`).
- **Retire:**
  - Valid ret lanes pop the head in lane order; deq = popcount(`ret_valid_i`).
  - Each popped entry is compared with its ret lane: mispredict = (entry.result != `ret_actual_i`).
  - Feedback for ret lane k appears on fb lane k.
- **PC check:** when entry.pc != `ret_pc_i` for a lane:
  - that lane's `fb_valid_o` is 0;
  - the entry is still popped;
  - `err_o` is set.
- **Underflow:** retiring more lanes than `count_o` sets `err_o`. Only the available entries pop, and excess lanes produce no feedback.
- **Overflow:** enqueueing more than the free entries sets `err_o`. Lanes beyond capacity are dropped (lane 0 kept first) and the queue never exceeds `P_DEPTH`.
- **Count update:** count_next = count + enq_accepted - deq_accepted.
- **Simultaneous enqueue and retire:**
  - Legal in the same cycle.
  - Retire sees only entries present at the start of the cycle; an entry enqueued in cycle N is retirable from N+1.
  - At full occupancy, retiring 2 and enqueueing 2 in one cycle is accepted with no error.
- **Flush:**
  - Retirements in the flush cycle are still validated and produce feedback.
  - Enqueues in the flush cycle are dropped.
  - After the edge, head = tail, count = 0.
- `full_o` = (`P_DEPTH` - count < 2), computed combinationally from the registered count.

## Timing
- All `fb_*` outputs are registered: a retire in cycle N gives feedback valid for exactly cycle N+1.
- `fb_valid_o` is 0 in any cycle following a cycle with no successful validation on that lane.
- `count_o`, `full_o` and `err_o` reflect state after the last clock edge.
- Reset (async, mid-operation allowed):
  - all `fb_*` = 0, `count_o` = 0, `full_o` = 0, `err_o` = 0;
  - head = tail = 0;
  - queue contents are don't-care.
  - Takes effect without a clock edge and holds while `rst_i` is high.
- Maximum throughput: 2 enqueues plus 2 retires per cycle, no bubbles.

## Test plan
- **Basic match:** enqueue lane 0 {pc=0x100, result=0x5, conf=0x1FF}, then retire {pc=0x100, actual=0x5} -> next cycle `fb_valid_o`=01, `fb_mispredict_o`[0]=0, `fb_conf_o`[0]=0x1FF, `fb_pc_o`[0]=0x100.
- **Dual-lane mispredict:**
  - Enqueue 2'b11 {0x200: result 7, 0x204: result 9}.
  - Retire 2'b11 with actuals 7 and 8 -> `fb_valid_o`=11, `fb_mispredict_o`=10.
  - `count_o` returns to 0.
- **Fill, wrap and simultaneous traffic:**
  - With `P_DEPTH`=16, enqueue 8×2 -> `count_o`=16, `full_o`=1.
  - Retire 2 while enqueueing 2 for 20 cycles -> `count_o` stays 16, FIFO order holds across pointer wrap, `err_o`=0.
- **Flush:**
  - 6 entries queued; `flush_i` with a retire of 1 and an enqueue of 2 in the same cycle.
  - -> one feedback next cycle; `count_o`=0; the following retire attempt sets `err_o`=1.
- **PC mismatch and overflow:**
  - Retire pc 0x300 against a head entry of 0x304 -> `fb_valid_o`[0]=0, `err_o`=1, entry popped.
  - Separately, enqueue 2 at `count_o`=15 -> only lane 0 accepted, `count_o`=16, `err_o`=1.
- **Async reset:** assert `rst_i` between clock edges with 5 entries queued and `fb_valid_o`=11 -> all outputs 0 immediately; after release, the first retire sets `err_o`.
